// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a ready/send handshake.
// Each byte is launched with a fresh rising edge on uart_send and retried on acknowledge timeout.
module uart_tx_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          ack_err,
    input  logic          uart_ready,
    output logic          uart_send,
    output logic [7:0]    uart_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_BUSY
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    tmo;
    state_t        state;
    logic          push;
    logic          pop;

    always_comb begin
        full  = count[AW];
        empty = (count == '0);
        push  = wr_en && !full && !flush;
        pop   = (state == S_IDLE) && !empty && uart_ready && !flush;
    end

    // Overflow looks only at the pre-edge full flag, so a same-cycle pop does not rescue the write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full && !flush;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            uart_send <= 1'b0;
            uart_data <= '0;
            tmo       <= '0;
            ack_err   <= 1'b0;
        end else begin
            ack_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        uart_data <= mem[rd_ptr];
                        uart_send <= 1'b1;
                        tmo       <= '0;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!uart_ready) begin
                        uart_send <= 1'b0;
                        state     <= S_BUSY;
                    end else if (tmo == TMO_LAST) begin
                        uart_send <= 1'b0;
                        ack_err   <= 1'b1;
                        state     <= S_GAP;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                S_GAP: begin
                    uart_send <= 1'b1;
                    tmo       <= '0;
                    state     <= S_SEND;
                end
                S_BUSY: begin
                    if (uart_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: queue-based reference model plus an automated transmitter
// that accepts after a programmable number of send-high cycles.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int T     = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          flush = 1'b0;
    logic          full, empty, overflow, ack_err, uart_send, uart_ready;
    logic [7:0]    uart_data;
    logic [AW:0]   count;

    logic          manual_ready = 1'b1;
    logic          tx_auto = 1'b0;
    logic          auto_ready = 1'b1;
    int            tx_cnt = 0, tx_busy = 0, tx_delay = 1;
    int            dly_min = 1, dly_max = 1, busy_min = 1, busy_max = 1;
    logic [7:0]    rx[$];

    int            checks = 0;
    int            failures = 0;

    // Reference model: byte queue plus the outstanding byte's age since launch.
    logic [7:0]    q[$];
    bit            m_active = 0, m_wait = 0, m_send = 0, m_ovf = 0, m_ack = 0;
    logic [7:0]    m_data = 8'h00;
    int            m_age = 0;

    assign uart_ready = tx_auto ? auto_ready : manual_ready;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(T)) dut (
        .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .ack_err(ack_err),
        .uart_ready(uart_ready), .uart_send(uart_send), .uart_data(uart_data)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (!tx_auto) begin
            auto_ready = 1'b1;
            tx_cnt = 0;
            tx_busy = 0;
        end else if (auto_ready) begin
            if (uart_send === 1'b1) begin
                tx_cnt++;
                if (tx_cnt >= tx_delay) begin
                    auto_ready = 1'b0;
                    rx.push_back(uart_data);
                    tx_cnt = 0;
                    tx_busy = $urandom_range(busy_max, busy_min);
                    tx_delay = $urandom_range(dly_max, dly_min);
                end
            end
        end else begin
            if (tx_busy > 1) tx_busy--;
            else auto_ready = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic model_step();
        int pre = q.size();
        m_ovf = 1'b0;
        m_ack = 1'b0;
        if (Reset) begin
            q.delete();
            m_active = 0; m_wait = 0; m_send = 0; m_data = 8'h00; m_age = 0;
            return;
        end
        if (m_active) begin
            if (m_send && !uart_ready) begin
                m_active = 0;
                m_wait = 1;
            end else begin
                m_age++;
                if (m_age % (T + 1) == T) m_ack = 1'b1;
            end
        end else if (m_wait) begin
            if (uart_ready) m_wait = 0;
        end else if (q.size() != 0 && uart_ready && !flush) begin
            m_data = q.pop_front();
            m_active = 1;
            m_age = 0;
        end
        if (flush) q.delete();
        else if (wr_en) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else q.push_back(wr_data);
        end
        m_send = m_active && ((m_age % (T + 1)) < T);
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    task automatic set_tx(input int dmin, input int dmax, input int bmin, input int bmax);
        dly_min = dmin; dly_max = dmax; busy_min = bmin; busy_max = bmax;
        tx_delay = $urandom_range(dmax, dmin);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        while ((m_active || m_wait || q.size() != 0 || uart_ready !== 1'b1) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (n >= bound) begin
            failures++;
            $display("FAIL %s_idle_wait waited=%0d limit=%0d", tag, n, bound);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; wr_en = 1'b1; wr_data = 8'hAA; tx_auto = 1'b0; manual_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (count !== '0) begin failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, count); end
            checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty cyc=%0d got=%b exp=1", i, empty); end
            checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full cyc=%0d got=%b exp=0", i, full); end
            checks++; if (uart_send !== 1'b0) begin failures++; $display("FAIL reset_send cyc=%0d got=%b exp=0", i, uart_send); end
            checks++; if (uart_data !== 8'h00) begin failures++; $display("FAIL reset_data cyc=%0d got=%02h exp=00", i, uart_data); end
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow cyc=%0d got=%b exp=0", i, overflow); end
        end
        Reset = 1'b0; wr_en = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_post_empty got=%b exp=1", empty); end
    endtask

    task automatic test_single();
        int hi = 0;
        rx.delete();
        set_tx(2, 2, 20, 20);
        tx_auto = 1'b1;
        wr_en = 1'b1; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count_push got=%0d exp=1", count); end
        checks++; if (uart_send !== 1'b0) begin failures++; $display("FAIL single_send_early got=%b exp=0", uart_send); end
        tick();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_count_pop got=%0d exp=0", count); end
        checks++; if (uart_send !== 1'b1) begin failures++; $display("FAIL single_send_launch got=%b exp=1", uart_send); end
        for (int i = 0; i < 30; i++) begin
            if (uart_send === 1'b1) hi++;
            checks++; if (uart_data !== 8'h41) begin failures++; $display("FAIL single_data cyc=%0d got=%02h exp=41", i, uart_data); end
            tick();
            checks++; if (uart_send !== m_send) begin failures++; $display("FAIL single_send cyc=%0d got=%b exp=%b", i, uart_send, m_send); end
        end
        checks++; if (hi != 2) begin failures++; $display("FAIL single_send_width got=%0d exp=2", hi); end
        wait_idle(100, "single");
        checks++; if (rx.size() != 1 || rx[0] !== 8'h41) begin failures++; $display("FAIL single_rx got_n=%0d exp_n=1", rx.size()); end
    endtask

    task automatic test_overflow();
        logic [AW:0] ec;
        int n = 0;
        tx_auto = 1'b0; manual_ready = 1'b0; rx.delete();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            ec = (i < DEPTH) ? (AW+1)'(i + 1) : (AW+1)'(DEPTH);
            checks++; if (count !== ec) begin failures++; $display("FAIL ovf_count i=%0d got=%0d exp=%0d", i, count, ec); end
            checks++; if (full !== (i >= DEPTH - 1)) begin failures++; $display("FAIL ovf_full i=%0d got=%b exp=%b", i, full, i >= DEPTH - 1); end
            checks++; if (overflow !== (i == DEPTH)) begin failures++; $display("FAIL ovf_pulse i=%0d got=%b exp=%b", i, overflow, i == DEPTH); end
        end
        wr_en = 1'b0;
        tick();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse_end got=%b exp=0", overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count_hold got=%0d exp=16", count); end
        set_tx(1, 3, 1, 4);
        tx_auto = 1'b1;
        while (!(rx.size() == DEPTH && !m_active && !m_wait) && n < 1500) begin
            tick();
            n++;
            ec = (AW+1)'(q.size());
            checks++; if (uart_send !== m_send) begin failures++; $display("FAIL drain_send cyc=%0d got=%b exp=%b", n, uart_send, m_send); end
            checks++; if (count !== ec) begin failures++; $display("FAIL drain_count cyc=%0d got=%0d exp=%0d", n, count, ec); end
        end
        checks++; if (rx.size() != DEPTH) begin failures++; $display("FAIL drain_bytes got=%0d exp=%0d", rx.size(), DEPTH); end
        for (int k = 0; k < DEPTH && k < rx.size(); k++) begin
            checks++; if (rx[k] !== 8'(k)) begin failures++; $display("FAIL drain_order k=%0d got=%02h exp=%02h", k, rx[k], 8'(k)); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_timeout();
        int acks = 0;
        tx_auto = 1'b0; manual_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (ack_err === 1'b1) acks++;
            checks++; if (uart_send !== m_send) begin failures++; $display("FAIL tmo_send cyc=%0d got=%b exp=%b", i, uart_send, m_send); end
            checks++; if (ack_err !== m_ack) begin failures++; $display("FAIL tmo_ack cyc=%0d got=%b exp=%b", i, ack_err, m_ack); end
            checks++; if (uart_data !== 8'h55) begin failures++; $display("FAIL tmo_data cyc=%0d got=%02h exp=55", i, uart_data); end
            checks++; if (count !== 5'd0) begin failures++; $display("FAIL tmo_count cyc=%0d got=%0d exp=0", i, count); end
        end
        checks++; if (acks != 5) begin failures++; $display("FAIL tmo_ack_total got=%0d exp=5", acks); end
        set_tx(1, 1, 2, 2);
        tx_auto = 1'b1;
        wait_idle(100, "timeout");
    endtask

    task automatic test_flush();
        logic [7:0] b0 = 8'h00;
        logic prev;
        int rises = 0;
        rx.delete();
        set_tx(2, 2, 30, 30);
        tx_auto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            if (i == 0) b0 = wr_data;
            tick();
        end
        checks++; if (count !== 5'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
        prev = uart_send;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_send === 1'b1 && prev !== 1'b1) rises++;
            prev = uart_send;
        end
        checks++; if (rises != 0) begin failures++; $display("FAIL flush_extra_send got=%0d exp=0", rises); end
        checks++; if (rx.size() != 1 || rx[0] !== b0) begin failures++; $display("FAIL flush_inflight got_n=%0d exp_n=1 exp_byte=%02h", rx.size(), b0); end
        wait_idle(100, "flush");
    endtask

    task automatic test_reset_midsend();
        tx_auto = 1'b0; manual_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'hAB;
        tick();
        wr_en = 1'b0;
        tick();
        checks++; if (uart_send !== 1'b1) begin failures++; $display("FAIL rst_mid_launch got=%b exp=1", uart_send); end
        manual_ready = 1'b0; Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (uart_send !== 1'b0) begin failures++; $display("FAIL rst_mid_send got=%b exp=0", uart_send); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (uart_send !== 1'b0) begin failures++; $display("FAIL rst_mid_hold cyc=%0d got=%b exp=0", i, uart_send); end
        end
        checks++; if (count !== 5'd2) begin failures++; $display("FAIL rst_mid_queued got=%0d exp=2", count); end
        manual_ready = 1'b1;
        tick();
        checks++; if (uart_send !== 1'b1) begin failures++; $display("FAIL rst_mid_relaunch got=%b exp=1", uart_send); end
        checks++; if (uart_data !== 8'h11) begin failures++; $display("FAIL rst_mid_data got=%02h exp=11", uart_data); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL rst_mid_count_after got=%0d exp=1", count); end
        set_tx(1, 1, 2, 2);
        tx_auto = 1'b1;
        wait_idle(200, "rst_mid");
    endtask

    task automatic test_random();
        logic [AW:0] ec;
        set_tx(1, 11, 1, 6);
        tx_auto = 1'b1;
        for (int i = 0; i < 900; i++) begin
            Reset   = ($urandom_range(255, 0) == 0);
            flush   = ($urandom_range(49, 0) == 0);
            wr_en   = ($urandom_range(2, 0) == 0);
            wr_data = 8'($urandom);
            tick();
            ec = (AW+1)'(q.size());
            checks++; if (count !== ec) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, ec); end
            checks++; if (empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b", i, empty); end
            checks++; if (full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rnd_full cyc=%0d got=%b", i, full); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", i, overflow, m_ovf); end
            checks++; if (ack_err !== m_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, ack_err, m_ack); end
            checks++; if (uart_send !== m_send) begin failures++; $display("FAIL rnd_send cyc=%0d got=%b exp=%b", i, uart_send, m_send); end
            checks++; if (uart_data !== m_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%02h exp=%02h", i, uart_data, m_data); end
        end
        Reset = 1'b0; flush = 1'b0; wr_en = 1'b0;
        wait_idle(3000, "random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_timeout();
        test_flush();
        test_reset_midsend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
